// File: rtl/cla_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// cla_add_arbiter_if
// Bundles every handshake and bus signal around cla_add_arbiter:
//   req0_* / req1_* : two multi-word add requesters (valid/ready, A, B, cin, last)
//   add_*           : operands to and result from the shared carry-lookahead adder
//   rsp_*           : registered response channel (valid/ready, sum, cout, id,
//                     last, trunc)
// Modports:
//   master : the arbiter itself
//   slave  : its environment (requesters, shared adder, response consumer)
// ---------------------------------------------------------------------------
interface cla_add_arbiter_if #(
    parameter int W = 64
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req0_last;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         req1_last;

    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_id;
    logic         rsp_last;
    logic         rsp_trunc;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_last,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_last,
        output req1_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, rsp_trunc,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_cin, req0_last,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_last,
        input  req1_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, rsp_trunc,
        output rsp_ready
    );
endinterface

// File: rtl/cla_add_arbiter.sv
// ---------------------------------------------------------------------------
// cla_add_arbiter
// Shares one external W-bit carry-lookahead adder between two requesters that
// issue multi-precision add bursts (LS word first). Inside a burst the carry
// out of each word feeds the next word's carry in. Arbitration is round-robin
// per burst; results come back one cycle after acceptance on a registered
// response channel tagged with the owning requester.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cla_add_arbiter_if.master (req0_*, req1_*, add_*, rsp_*)
// Parameters:
//   W         : operand / sum width, equal to the shared adder width
//   MAX_BEATS : longest burst; a burst reaching it without last is cut short
// ---------------------------------------------------------------------------
module cla_add_arbiter #(
    parameter int W         = 64,
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    cla_add_arbiter_if.master bus
);
    localparam int            BW        = $clog2(MAX_BEATS) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_reg;
    logic          owner_reg;
    logic          rr_ptr_reg;
    logic          chain_c_reg;
    logic [BW-1:0] beat_reg;

    logic          rsp_valid_reg;
    logic [W-1:0]  rsp_sum_reg;
    logic          rsp_cout_reg;
    logic          rsp_id_reg;
    logic          rsp_last_reg;
    logic          rsp_trunc_reg;

    // Requester signals gathered into arrays so they can be indexed by id.
    logic [1:0]    req_valid;
    logic [1:0]    req_cin;
    logic [1:0]    req_last;
    logic [1:0]    req_ready;
    logic [W-1:0]  req_a [2];
    logic [W-1:0]  req_b [2];

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_cin   = {bus.req1_cin,   bus.req0_cin};
    assign req_last  = {bus.req1_last,  bus.req0_last};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    logic          grant_valid;
    logic          grant_id;
    logic          slot_free;
    logic          accept;
    logic          first_word;
    logic [BW-1:0] beat_num;
    logic          forced_end;
    logic          word_last;
    logic          burst_end;

    // Grant: the burst owner is locked in while a burst is open, even while it
    // has no word to offer, so the other requester cannot slip in mid-chain.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_reg == BURST) begin
            grant_id    = owner_reg;
            grant_valid = req_valid[owner_reg];
        end else if (&req_valid) begin
            grant_id    = rr_ptr_reg;
            grant_valid = 1'b1;
        end else begin
            grant_id    = req_valid[1];
            grant_valid = |req_valid;
        end
    end

    // A new word may be taken when the response register is empty or is being
    // drained this same cycle, which sustains one word per cycle.
    assign slot_free  = !rsp_valid_reg || bus.rsp_ready;
    assign accept     = grant_valid && slot_free;
    assign first_word = (state_reg == IDLE);
    assign beat_num   = beat_reg + 1'b1;
    assign forced_end = (beat_num == LAST_BEAT);
    assign word_last  = req_last[grant_id];
    assign burst_end  = word_last || forced_end;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    // Operands are steered while a grant exists; the adder sees zeros otherwise.
    assign bus.add_a   = grant_valid ? req_a[grant_id] : '0;
    assign bus.add_b   = grant_valid ? req_b[grant_id] : '0;
    assign bus.add_cin = grant_valid && (first_word ? req_cin[grant_id] : chain_c_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            chain_c_reg   <= 1'b0;
            beat_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_last_reg  <= 1'b0;
            rsp_trunc_reg <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid_reg <= 1'b1;
                rsp_sum_reg   <= bus.add_sum;
                rsp_cout_reg  <= bus.add_cout;
                rsp_id_reg    <= grant_id;
                rsp_last_reg  <= burst_end;
                rsp_trunc_reg <= forced_end && !word_last;
                chain_c_reg   <= bus.add_cout;
                if (burst_end) begin
                    state_reg  <= IDLE;
                    beat_reg   <= '0;
                    rr_ptr_reg <= !grant_id;
                end else begin
                    state_reg <= BURST;
                    owner_reg <= grant_id;
                    beat_reg  <= beat_num;
                end
            end else if (bus.rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_sum   = rsp_sum_reg;
    assign bus.rsp_cout  = rsp_cout_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_last  = rsp_last_reg;
    assign bus.rsp_trunc = rsp_trunc_reg;
endmodule

// File: doc/cla_add_arbiter.md
Name: cla_add_arbiter

Overview:
- Shares one external 64-bit carry-lookahead adder between two requesters.
- Each requester issues multi-word (multi-precision) add bursts; within a burst, the carry out of each word chains into the next word's carry in.
- Arbitration is round-robin at burst granularity. Results return on a single registered response channel tagged with the requester id.
- Sits between the two client datapaths and the shared adder instance.

Parameters:
- W, 64, operand/sum width; must match the shared adder width.
- MAX_BEATS, 4, maximum words per burst (≥1); beat counter width is clog2(MAX_BEATS)+1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 word valid.
- req0_ready  out  1  requester 0 word accepted when valid&ready.
- req0_a  in  W  requester 0 operand A word (LS word first).
- req0_b  in  W  requester 0 operand B word.
- req0_cin  in  1  carry in; used on the first word of a burst only.
- req0_last  in  1  marks the final word of the burst.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_last: same as requester 0, for requester 1.
- add_a  out  W  to shared adder operand A (combinational mux).
- add_b  out  W  to shared adder operand B.
- add_cin  out  1  to shared adder carry in.
- add_sum  in  W  from shared adder, combinational.
- add_cout  in  1  from shared adder.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  response consumer ready.
- rsp_sum  out  W  registered sum word.
- rsp_cout  out  1  registered carry out of this word.
- rsp_id  out  1  owner requester of this word.
- rsp_last  out  1  final word of the burst (requester last or forced).
- rsp_trunc  out  1  burst was force-terminated at MAX_BEATS without last.

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=IDLE, rr_ptr=0, chain_c=0, beat=0.
  - rsp_valid=0; rsp_sum=0; rsp_cout=0; rsp_id=0; rsp_last=0; rsp_trunc=0.
  - The in-flight burst is discarded; no partial response is emitted.
- slot_free = !rsp_valid | rsp_ready. A word is accepted only when slot_free.
- States:
  - IDLE:
    - Grant goes to the valid requester; if both are valid, grant goes to rr_ptr.
    - The grant is combinational; the first word is accepted in the same cycle if slot_free.
    - If the accepted word has last=1, stay IDLE; otherwise go to BURST(owner).
  - BURST(k):
    - Only requester k may be granted; req(!k)_ready=0.
    - Leave to IDLE when the accepted word has last=1 or beat reaches MAX_BEATS.
- Adder drive:
  - add_a/add_b come from the granted requester.
  - add_cin = reqk_cin on the first word, else chain_c.
  - With no grant: add_a=0, add_b=0, add_cin=0.
- On accept:
  - rsp_sum<=add_sum, rsp_cout<=add_cout, rsp_id<=k, rsp_valid<=1.
  - chain_c<=add_cout; beat<=beat+1 (reset to 0 at burst end).
  - Latency: exactly 1 cycle from accept to rsp_valid.
- rsp_last/rsp_trunc:
  - rsp_last=1 if the accepted word has last=1 or is beat number MAX_BEATS.
  - rsp_trunc=1 only when forced (last=0 at beat MAX_BEATS).
  - With MAX_BEATS=1, every word ends its burst.
- rr_ptr <= !k when a burst owned by k ends. It is unchanged otherwise.
- Response hold: while rsp_valid & !rsp_ready, all rsp_* outputs are stable and both req*_ready=0.
  - Accept and drain in the same cycle is allowed, giving full throughput of 1 word/cycle.
- Valid drop mid-burst: if owner k deasserts valid, the controller waits in BURST(k).
  - chain_c and beat are held; the other requester is never granted until the burst ends.
- Simultaneous events:
  - A burst end and a new request from the other requester in the same cycle: the new request is granted the next cycle (IDLE is always at least one cycle between bursts, except single-word bursts from IDLE).
  - A single-word burst from IDLE returns to IDLE, and rr_ptr toggles.
- Operand carry is unsigned; overflow out of the final word is reported only via rsp_cout on rsp_last.

Test Plan:
- Single word: req0 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, last=1 → next cycle rsp_sum=0, rsp_cout=1, rsp_id=0, rsp_last=1, rsp_trunc=0.
- 128-bit chain: req1 words (a=0xFFFF…FF, b=1, cin=0), then (a=0, b=0, last=1) → rsp words sum=0/cout=1, then sum=1/cout=0/last=1.
- Contention: both valid from reset with 2-word bursts:
  - order of rsp_id is 0,0,1,1;
  - the second burst's first word is not affected by the first burst's chain_c;
  - req1_ready stays 0 during burst 0.
- Backpressure: rsp_ready=0 for 3 cycles mid-burst → rsp_* stable, req ready=0, no word lost; resume at 1 word/cycle.
- Truncation: MAX_BEATS=4, req0 sends 5 words with last=0 → beat 4 has rsp_last=1, rsp_trunc=1; the 5th word starts a new burst using req0_cin.
- Reset mid-burst: assert rst after beat 2 of 4 → rsp_valid=0 immediately; after release, a new req1 burst uses req1_cin (not the stale chain_c) and rr_ptr=0.
